// File: rtl/jpeg_pkg.sv
// Shared definitions for the JPEG entropy-coding back end.
//   - byte-stuffing constants (a 0xFF data byte must be followed by 0x00)
//   - JPEG_MAX_CODE_BITS: widest code word produced by jpeg_huffman_encode
//   - packer_state_e: state encoding of jpeg_bitstream_packer
//   - clamp_len(): saturates a code-word length to JPEG_MAX_CODE_BITS
package jpeg_pkg;

    localparam logic [7:0] JPEG_STUFF_TRIGGER = 8'hFF;
    localparam logic [7:0] JPEG_STUFF_BYTE    = 8'h00;
    localparam int         JPEG_MAX_CODE_BITS = 32;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_STUFF,
        ST_FLUSH_PAD,
        ST_FLUSH_DRAIN
    } packer_state_e;

    function automatic logic [5:0] clamp_len(input logic [5:0] len);
        return (len > 6'(JPEG_MAX_CODE_BITS)) ? 6'(JPEG_MAX_CODE_BITS) : len;
    endfunction

endpackage

// File: rtl/jpeg_bitstream_packer_if.sv
// Bus between the Huffman encoder / scan writer and jpeg_bitstream_packer.
//   in_wren/in_length/in_data/in_ready : code-word write port
//   flush/busy/flush_done               : end-of-scan pad-and-drain control
//   out_valid/out_data/out_ready        : byte stream with valid/ready
//   overflow                            : sticky dropped-write flag
// modport slave  : the packer
// modport master : the surrounding logic (encoder side + byte consumer)
interface jpeg_bitstream_packer_if;
    import jpeg_pkg::*;

    logic                          in_wren;
    logic [5:0]                    in_length;
    logic [JPEG_MAX_CODE_BITS-1:0] in_data;
    logic                          in_ready;
    logic                          flush;
    logic                          out_valid;
    logic [7:0]                    out_data;
    logic                          out_ready;
    logic                          busy;
    logic                          flush_done;
    logic                          overflow;

    modport slave (
        input  in_wren, in_length, in_data, flush, out_ready,
        output in_ready, out_valid, out_data, busy, flush_done, overflow
    );

    modport master (
        output in_wren, in_length, in_data, flush, out_ready,
        input  in_ready, out_valid, out_data, busy, flush_done, overflow
    );

endinterface

// File: rtl/jpeg_byte_stuffer.sv
// Output byte register with valid/ready hand-off and 0xFF -> 0xFF,0x00
// stuffing. Knows nothing about the bit accumulator.
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   load_i, byte_i  : load a new byte (only honoured when slot_free_o is high)
//   out_ready_i     : downstream takes the current byte
//   out_valid_o     : out_data_o holds a byte
//   out_data_o      : byte presented downstream (held while not accepted)
//   slot_free_o     : a load this cycle will be taken
//   stuff_fire_o    : the pending 0x00 is being loaded this cycle
module jpeg_byte_stuffer
    import jpeg_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       load_i,
    input  logic [7:0] byte_i,
    input  logic       out_ready_i,
    output logic       out_valid_o,
    output logic [7:0] out_data_o,
    output logic       slot_free_o,
    output logic       stuff_fire_o
);

    logic       valid_q, valid_d;
    logic [7:0] data_q,  data_d;
    logic       pend_q,  pend_d;
    logic       out_free;

    // The register can take a new byte when empty or being drained now.
    assign out_free     = !valid_q || out_ready_i;
    assign stuff_fire_o = pend_q && out_free;
    // A pending stuff byte owns the next free slot ahead of any new data.
    assign slot_free_o  = out_free && !pend_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        pend_d  = pend_q;
        if (out_free) begin
            valid_d = 1'b0;
        end
        if (stuff_fire_o) begin
            valid_d = 1'b1;
            data_d  = JPEG_STUFF_BYTE;
            pend_d  = 1'b0;
        end else if (load_i && out_free) begin
            valid_d = 1'b1;
            data_d  = byte_i;
            pend_d  = (byte_i == JPEG_STUFF_TRIGGER);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= 8'h00;
            pend_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            pend_q  <= pend_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

endmodule

// File: rtl/jpeg_bitstream_packer.sv
// Packs variable-length code words MSB-first into a byte stream with JPEG
// byte stuffing; on flush pads the last partial byte with 1s and drains.
//   clock  : single rising-edge clock
//   nreset : asynchronous active-low reset (discards all buffered bits)
//   bus    : jpeg_bitstream_packer_if.slave (write port, flush control,
//            byte output, status)
// BUF_BITS is the accumulator depth; must be >= 40 and a multiple of 8.
module jpeg_bitstream_packer
    import jpeg_pkg::*;
#(
    parameter int BUF_BITS = 64
) (
    input  logic                   clock,
    input  logic                   nreset,
    jpeg_bitstream_packer_if.slave bus
);

    localparam int CNT_W = $clog2(BUF_BITS + 8) + 1;
    localparam int LOW_W = BUF_BITS - JPEG_MAX_CODE_BITS;
    localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(BUF_BITS - JPEG_MAX_CODE_BITS);
    localparam logic [CNT_W-1:0] BYTE_BITS = CNT_W'(8);

    packer_state_e       state_q, state_d;
    logic [BUF_BITS-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                flushing_q, flushing_d;
    logic                overflow_q, overflow_d;

    logic [5:0]          len;
    logic [31:0]         mask32;
    logic [31:0]         code_msb;
    logic [BUF_BITS-1:0] app_bits;
    logic [BUF_BITS-1:0] pad_mask;
    logic [CNT_W-1:0]    cnt_up;
    logic [7:0]          ext_byte;
    logic                in_ready_w;
    logic                accept;
    logic                extract;
    logic                drain_done;
    logic                slot_free;
    logic                stuff_fire;

    assign in_ready_w = (cnt_q <= READY_MAX) &&
                        (state_q != ST_FLUSH_PAD) && (state_q != ST_FLUSH_DRAIN);
    assign accept     = bus.in_wren && in_ready_w;

    // Left-justify the code word, then slide it down behind the cnt_q
    // bits already held so it lands directly after them.
    assign len      = clamp_len(bus.in_length);
    assign mask32   = (len == 6'd32) ? 32'hFFFF_FFFF : ((32'd1 << len) - 32'd1);
    assign code_msb = (bus.in_data & mask32) << (6'd32 - len);
    assign app_bits = {code_msb, {LOW_W{1'b0}}} >> cnt_q;

    // Pad region: bit positions cnt_q .. cnt_up-1 counted from the MSB.
    always_comb begin
        cnt_up      = cnt_q + CNT_W'(7);
        cnt_up[2:0] = 3'b000;
    end
    assign pad_mask = ({BUF_BITS{1'b1}} >> cnt_q) & ~({BUF_BITS{1'b1}} >> cnt_up);

    assign ext_byte = acc_q[BUF_BITS-1 -: 8];

    always_comb begin
        state_d    = state_q;
        flushing_d = flushing_q;
        overflow_d = overflow_q | (bus.in_wren && !in_ready_w);
        extract    = 1'b0;
        drain_done = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                // A flush cycle only appends; extraction resumes in the drain.
                if (bus.flush) begin
                    state_d    = ST_FLUSH_PAD;
                    flushing_d = 1'b1;
                end else if (cnt_q >= BYTE_BITS && slot_free) begin
                    extract = 1'b1;
                    if (ext_byte == JPEG_STUFF_TRIGGER) state_d = ST_STUFF;
                end
            end
            ST_STUFF: begin
                if (stuff_fire) state_d = flushing_q ? ST_FLUSH_DRAIN : ST_RUN;
            end
            ST_FLUSH_PAD: begin
                state_d = ST_FLUSH_DRAIN;
            end
            ST_FLUSH_DRAIN: begin
                if (cnt_q >= BYTE_BITS && slot_free) begin
                    extract = 1'b1;
                    if (ext_byte == JPEG_STUFF_TRIGGER) state_d = ST_STUFF;
                end else if (cnt_q == '0 && slot_free) begin
                    drain_done = 1'b1;
                    flushing_d = 1'b0;
                    state_d    = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase

        // Writes are never accepted in FLUSH_PAD, so padding and appending
        // cannot collide.
        if (state_q == ST_FLUSH_PAD) begin
            acc_d = acc_q | pad_mask;
            cnt_d = cnt_up;
        end else begin
            acc_d = acc_q | (accept ? app_bits : '0);
            if (extract) acc_d = acc_d << 8;
            cnt_d = cnt_q + (accept ? CNT_W'(len) : '0) - (extract ? BYTE_BITS : '0);
        end
    end

    // The accumulator is reset too: appends OR into it, so bits past cnt_q
    // must be zero.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q    <= ST_RUN;
            acc_q      <= '0;
            cnt_q      <= '0;
            flushing_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            flushing_q <= flushing_d;
            overflow_q <= overflow_d;
        end
    end

    jpeg_byte_stuffer u_stuffer (
        .clk_i        (clock),
        .rst_ni       (nreset),
        .load_i       (extract),
        .byte_i       (ext_byte),
        .out_ready_i  (bus.out_ready),
        .out_valid_o  (bus.out_valid),
        .out_data_o   (bus.out_data),
        .slot_free_o  (slot_free),
        .stuff_fire_o (stuff_fire)
    );

    assign bus.in_ready   = in_ready_w;
    assign bus.busy       = flushing_q && !drain_done;
    assign bus.flush_done = drain_done;
    assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_jpeg_bitstream_packer.sv
module tb_jpeg_bitstream_packer;

    logic clk;
    logic nreset;

    jpeg_bitstream_packer_if bus();

    jpeg_bitstream_packer #(.BUF_BITS(64)) dut (
        .clock  (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int         got_base = 0;
    int         done_cnt = 0;

    // Inputs only change 1 time unit after a rising edge, so whatever is
    // seen at the falling edge is what the next rising edge consumes.
    always @(negedge clk) begin
        if (nreset && bus.out_valid && bus.out_ready) got_q.push_back(bus.out_data);
        if (nreset && bus.flush_done) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] data, input logic [5:0] len);
        bus.in_wren   = 1'b1;
        bus.in_data   = data;
        bus.in_length = len;
        tick();
        bus.in_wren   = 1'b0;
        bus.in_data   = 32'h0;
        bus.in_length = 6'd0;
    endtask

    task automatic check_stream(input string tag);
        chk({tag, "_count"}, 32'(got_q.size() - got_base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (got_base + i < got_q.size())
                chk($sformatf("%s_byte%0d", tag, i), 32'(got_q[got_base + i]), 32'(exp_q[i]));
        end
        got_base = got_q.size();
        exp_q.delete();
    endtask

    task automatic do_flush(input string tag);
        int n;
        int d0;
        d0 = done_cnt;
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
        n = 0;
        while (!bus.flush_done && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_done"}, 32'(bus.flush_done), 32'd1);
        tick();
        tick();
        chk({tag, "_pulses"}, 32'(done_cnt - d0), 32'd1);
        chk({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int d0;
        nreset        = 1'b0;
        bus.in_wren   = 1'b0;
        bus.in_length = 6'd0;
        bus.in_data   = 32'h0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;

        // reset state
        #12;
        chk("rst_out_valid",  32'(bus.out_valid),  32'd0);
        chk("rst_out_data",   32'(bus.out_data),   32'h00);
        chk("rst_busy",       32'(bus.busy),       32'd0);
        chk("rst_flush_done", 32'(bus.flush_done), 32'd0);
        chk("rst_overflow",   32'(bus.overflow),   32'd0);
        tick();
        nreset = 1'b1;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // basic packing: 101 + 11110 -> 1011_1110
        wr(32'h5, 6'd3);
        wr(32'h1E, 6'd5);
        chk("basic_not_yet", 32'(bus.out_valid), 32'd0);
        tick();
        chk("basic_valid", 32'(bus.out_valid), 32'd1);
        chk("basic_data",  32'(bus.out_data),  32'hBE);
        tick();
        chk("basic_drained", 32'(bus.out_valid), 32'd0);
        exp_q = '{8'hBE};
        check_stream("basic");

        // stuffing: FF then 00 on consecutive cycles
        wr(32'hFF, 6'd8);
        tick();
        chk("stuff_ff", 32'(bus.out_data), 32'hFF);
        tick();
        chk("stuff_00_valid", 32'(bus.out_valid), 32'd1);
        chk("stuff_00",       32'(bus.out_data),  32'h00);
        tick();
        chk("stuff_end", 32'(bus.out_valid), 32'd0);
        exp_q = '{8'hFF, 8'h00};
        check_stream("stuff1");

        // 1_1111_1110 then flush: 11111111 | 0 padded with 1111111
        wr(32'h1FE, 6'd9);
        do_flush("stuff2");
        exp_q = '{8'hFF, 8'h00, 8'h7F};
        check_stream("stuff2");

        // flush padding
        wr(32'h0, 6'd1);
        do_flush("pad0");
        exp_q = '{8'h7F};
        check_stream("pad0");

        wr(32'h1, 6'd1);
        do_flush("pad1");
        exp_q = '{8'hFF, 8'h00};
        check_stream("pad1");

        // flush with empty buffer: busy one cycle, then flush_done
        d0 = done_cnt;
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("empty_busy",     32'(bus.busy),       32'd1);
        chk("empty_not_done", 32'(bus.flush_done), 32'd0);
        tick();
        chk("empty_done",      32'(bus.flush_done), 32'd1);
        chk("empty_busy_fall", 32'(bus.busy),       32'd0);
        tick();
        chk("empty_done_pulse", 32'(bus.flush_done), 32'd0);
        chk("empty_pulses",     32'(done_cnt - d0),  32'd1);
        check_stream("empty");

        // in_length above 32 behaves as 32
        wr(32'hC0FFEE11, 6'd40);
        idle(6);
        exp_q = '{8'hC0, 8'hFF, 8'h00, 8'hEE, 8'h11};
        check_stream("clamp");

        // back-pressure
        bus.out_ready = 1'b0;
        wr(32'h12345678, 6'd32);
        chk("bp_ready_2nd", 32'(bus.in_ready), 32'd1);
        wr(32'h12345678, 6'd32);
        chk("bp_ready_3rd", 32'(bus.in_ready),  32'd0);
        chk("bp_loaded",    32'(bus.out_valid), 32'd1);
        idle(3);
        chk("bp_hold_data",  32'(bus.out_data),  32'h12);
        chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        idle(12);
        exp_q = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h12, 8'h34, 8'h56, 8'h78};
        check_stream("bp");
        chk("bp_overflow", 32'(bus.overflow), 32'd0);

        // overflow: third word is dropped
        bus.out_ready = 1'b0;
        wr(32'h11223344, 6'd32);
        wr(32'h55667788, 6'd32);
        chk("ovf_not_ready", 32'(bus.in_ready), 32'd0);
        wr(32'hDEADBEEF, 6'd32);
        chk("ovf_set", 32'(bus.overflow), 32'd1);
        bus.out_ready = 1'b1;
        idle(12);
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        check_stream("ovf");
        chk("ovf_sticky", 32'(bus.overflow), 32'd1);

        // reset mid-stream
        wr(32'hABC, 6'd12);
        tick();
        chk("mid_valid_before", 32'(bus.out_valid), 32'd1);
        chk("mid_data_before",  32'(bus.out_data),  32'hAB);
        #1;
        nreset = 1'b0;
        #1;
        chk("mid_valid_rst", 32'(bus.out_valid), 32'd0);
        chk("mid_data_rst",  32'(bus.out_data),  32'h00);
        chk("mid_ovf_rst",   32'(bus.overflow),  32'd0);
        tick();
        nreset = 1'b1;
        #1;
        chk("mid_ready", 32'(bus.in_ready), 32'd1);
        wr(32'hA5, 6'd8);
        idle(4);
        exp_q = '{8'hA5};
        check_stream("mid");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jpeg_bitstream_packer.md
# jpeg_bitstream_packer

Downstream stage of `jpeg_huffman_encode`. Accepts its variable-length code words (up to 32 bits per write), concatenates them MSB-first into a continuous bitstream, and emits bytes with JPEG byte stuffing: every emitted 0xFF is followed by 0x00. On `flush`, it pads the final partial byte with 1s, as required at end of scan, and drains. The output byte stream feeds the scan-data writer or FIFO.

## Interface
- `BUF_BITS`, 64, accumulator depth in bits; must be ≥ 40.
- `clock` in 1: single clock, rising edge.
- `nreset` in 1: asynchronous, active-low reset.
- `in_wren` in 1: code-word write strobe.
- `in_length` in 6: number of valid bits, 0..32; values >32 are treated as 32.
- `in_data` in 32: code word, right-aligned; bit `in_length-1` is sent first.
- `in_ready` out 1: a write this cycle is accepted.
- `flush` in 1: pad to a byte boundary with 1s and drain.
- `out_valid` out 1: `out_data` holds a byte.
- `out_data` out 8: bitstream byte.
- `out_ready` in 1: downstream accepts the byte.
- `busy` out 1: a flush is in progress.
- `flush_done` out 1: one-cycle pulse when the flush drain is complete.
- `overflow` out 1: sticky; a write arrived while `in_ready` was low.

## Operation
- **State.** Accumulator `acc[BUF_BITS-1:0]` holds valid bits MSB-aligned. Count is `cnt`, range 0..`BUF_BITS`. A state machine runs with states RUN, STUFF, FLUSH_PAD, FLUSH_DRAIN.
- **in_ready.** `in_ready = (cnt <= BUF_BITS-32) && state != FLUSH_PAD && state != FLUSH_DRAIN`. It is computed from registered state only.
- **Accepted write.** The low `in_length` bits are appended after the current `cnt` valid bits, and `cnt += in_length`. A length of 0 is a no-op.
- **Write while `in_ready` low.** The data is dropped and `overflow` is set. `overflow` clears only on reset.
- **Byte output (RUN).** The output register is empty or being consumed (`!out_valid || out_ready`) and `cnt >= 8`: load the top 8 bits into `out_data`, set `out_valid`, shift `acc` left 8, and `cnt -= 8`. Append and extract may happen in the same cycle; the count update is `cnt + in_length - 8`.
- **Byte stuffing.** If the loaded byte is 0xFF, go to STUFF. In STUFF, the next free output slot gets 0x00 with no extract. Then return to RUN, or to FLUSH_DRAIN if flushing. Writes are still accepted in STUFF.
- **Flush.** `flush` is sampled only in RUN. If `in_wren` and `flush` are both asserted, the write is appended first, then the flush applies.
- **FLUSH_PAD.** If `cnt mod 8 != 0`, fill the remaining bits of the last byte with 1s and round `cnt` up to a multiple of 8. This takes one cycle. Then go to FLUSH_DRAIN.
- **FLUSH_DRAIN.** Extract bytes as in RUN, with stuffing applied to padded bytes too. When `cnt == 0`, no stuff is pending and `out_valid` is low (or its byte is consumed this cycle), pulse `flush_done`, clear `busy`, and return to RUN.
- **Flush with empty buffer.** `busy` is high for one cycle, then `flush_done` pulses; no bytes are emitted.
- **Output holding.** `out_valid` and `out_data` stay stable while `out_ready` is low.

## Timing
- **Reset values.** `out_valid`=0, `out_data`=0x00, `busy`=0, `flush_done`=0, `overflow`=0, `cnt`=0, state RUN. `in_ready` reads 1 once reset deasserts.
- **Reset mid-operation.** All buffered bits and any pending stuff byte are discarded immediately (asynchronous).
- **Latency.** A write accepted at edge N that completes a byte gives `out_valid`=1 after edge N+1.
- **Throughput.** One byte per cycle. Each stuffed 0x00 costs one extra output cycle. `flush` is followed by 1 pad cycle plus the drain.
- **Back-pressure.** With `out_ready` held low, the buffer accepts writes until `cnt > BUF_BITS-32`.
- **busy.** Rises the cycle after `flush` is sampled and falls in the same cycle `flush_done` pulses.

## Structure
- Shared package `jpeg_pkg`:
  - constants `JPEG_STUFF_TRIGGER`=8'hFF and `JPEG_STUFF_BYTE`=8'h00;
  - the packer state enum;
  - `JPEG_MAX_CODE_BITS`=32, shared with `jpeg_huffman_encode`.
- One natural sub-module, `jpeg_byte_stuffer`. It is the output register with valid/ready and the STUFF insertion, isolated from accumulator logic. The packer drives it with a byte and a load strobe and reads back a slot-free indication.

## Test plan
- **Basic packing.** Write (0b101, len 3) then (0b11110, len 5), `out_ready`=1 → single byte 0xBE, one cycle after the second write.
- **Stuffing.** Write (0xFF, len 8) → bytes 0xFF then 0x00 on consecutive cycles; (0x1FE, len 9) followed by flush → 0xFF, 0x00, 0x7F.
- **Flush padding.** Write (0b0, len 1) then flush → 0x7F and `flush_done`. Write (0b1, len 1) then flush → 0xFF, 0x00, `flush_done`. Flush with empty buffer → no bytes, `flush_done` two cycles after `flush`.
- **Back-pressure.** Hold `out_ready`=0 and write (0x12345678, len 32) twice → the first byte loads into the output register, and the second write is still accepted. A third write sees `in_ready`=0. Release `out_ready` → 12 34 56 78 12 34 56 78 in order, with `overflow`=0.
- **Overflow.** Force a write while `in_ready`=0 → `overflow`=1 stays set, and the output stream excludes the dropped word.
- **Reset mid-stream.** Write (0xABC, len 12), assert `nreset` low mid-cycle → `out_valid`=0 immediately. After release, write (0xA5, len 8) → output is 0xA5 only.
